// File: rtl/ecc_pkg.sv
// ecc_pkg: constants shared by the ECC encoder/decoder top and its result
// collector.
//   ecc_mode_e     operating mode codes (EO / DO / FC / reserved)
//   ecc_err_e      num_of_errors codes (none / single / double / reserved)
//   effective_err  error code as seen by the collector for a given mode
package ecc_pkg;

  typedef enum logic [1:0] {
    MODE_EO   = 2'b00,
    MODE_DO   = 2'b01,
    MODE_FC   = 2'b10,
    MODE_RSVD = 2'b11
  } ecc_mode_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SINGLE = 2'b01,
    ERR_DOUBLE = 2'b10,
    ERR_RSVD   = 2'b11
  } ecc_err_e;

  // Encode-only (and the reserved mode, which behaves as encode-only) never
  // reports errors, whatever the decoder side happens to present.
  function automatic logic [1:0] effective_err(input logic [1:0] mode,
                                               input logic [1:0] err);
    case (mode)
      MODE_DO, MODE_FC: return err;
      default:          return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ecc_result_collector_if.sv
// ecc_result_collector_if: valid/ready result stream from the collector to
// its consumer.
//   res_valid  head entry present         (master -> slave)
//   res_ready  consumer takes the head    (slave  -> master)
//   res_data   head data word             (master -> slave)
//   res_err    head error code            (master -> slave)
interface ecc_result_collector_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_err;

  modport master (output res_valid, output res_data, output res_err, input res_ready);
  modport slave  (input res_valid, input res_data, input res_err, output res_ready);
endinterface

// File: rtl/ecc_sync_fifo.sv
// ecc_sync_fifo: single-clock FIFO with wrap-bit pointers.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      synchronous empty; overrides push and pop
//   push_i       write wr_data_i (accepted if not full, or full with a pop)
//   pop_i        drop the head (ignored while empty)
//   rd_data_o    head entry, reads 0 while empty
//   full_o       DEPTH entries held
//   empty_o      no entries held
module ecc_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o && !flush_i;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ecc_result_collector.sv
// ecc_result_collector: captures each ECC result on op_done into a FIFO,
// streams it out on res_if, and keeps saturating statistics.
//   clk, rst        clock, asynchronous active-low reset
//   clear           synchronous flush of FIFO, counters and overflow
//   mode            ECC top mode (EO/DO/FC; reserved acts as EO)
//   data_in, err_in ECC top data_out and num_of_errors
//   op_done         ECC top operation_done, one push per high cycle
//   res_if          result stream (master side)
//   cnt_total       accepted plus dropped operations
//   cnt_single      operations reporting a single (corrected) error
//   cnt_double      operations reporting a double or reserved error code
//   overflow        sticky: a result was dropped on a full FIFO
module ecc_result_collector
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  op_done,
  input  logic [1:0]            err_in,
  ecc_result_collector_if.master res_if,
  output logic [CNT_WIDTH-1:0]  cnt_total,
  output logic [CNT_WIDTH-1:0]  cnt_single,
  output logic [CNT_WIDTH-1:0]  cnt_double,
  output logic                  overflow
);
  localparam int unsigned          EW      = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           err_eff;
  logic [EW-1:0]        head;
  logic                 fifo_full, fifo_empty;
  logic                 drop;
  logic [CNT_WIDTH-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_WIDTH-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_WIDTH-1:0] cnt_double_q, cnt_double_d;
  logic                 overflow_q, overflow_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  assign err_eff = effective_err(mode, err_in);
  // When full, fifo_empty is 0, so the head leaves exactly when res_ready is high.
  assign drop    = op_done && fifo_full && !res_if.res_ready;

  ecc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush_i   (clear),
    .push_i    (op_done),
    .pop_i     (res_if.res_ready),
    .wr_data_i ({data_in, err_eff}),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign res_if.res_valid = !fifo_empty;
  assign res_if.res_data  = head[EW-1:2];
  assign res_if.res_err   = head[1:0];

  always_comb begin
    cnt_total_d  = cnt_total_q;
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    overflow_d   = overflow_q;
    if (clear) begin
      cnt_total_d  = '0;
      cnt_single_d = '0;
      cnt_double_d = '0;
      overflow_d   = 1'b0;
    end else if (op_done) begin
      cnt_total_d = sat_inc(cnt_total_q);
      if (err_eff == ERR_SINGLE) cnt_single_d = sat_inc(cnt_single_q);
      if (err_eff[1])            cnt_double_d = sat_inc(cnt_double_q);
      if (drop)                  overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_total_q  <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_total_q  <= cnt_total_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cnt_total  = cnt_total_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ecc_result_collector.sv
// Testbench for ecc_result_collector. A second instance with 4-bit counters
// shares all stimulus so that counter saturation is reached in a few cycles.
module tb_ecc_result_collector;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, clear, op_done, ready;
  logic [1:0]    mode, err_in;
  logic [DW-1:0] data_in;

  logic [15:0] cnt_total, cnt_single, cnt_double;
  logic        overflow;
  logic [3:0]  s_total, s_single, s_double;
  logic        s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {data, err}, plain integer counts.
  logic [DW+1:0] mq[$];
  int m_total, m_single, m_double;
  bit m_ovf;

  ecc_result_collector_if #(.DATA_WIDTH(DW)) rif ();
  ecc_result_collector_if #(.DATA_WIDTH(DW)) rif_s ();

  assign rif.res_ready   = ready;
  assign rif_s.res_ready = ready;

  ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .data_in(data_in),
    .op_done(op_done), .err_in(err_in), .res_if(rif),
    .cnt_total(cnt_total), .cnt_single(cnt_single), .cnt_double(cnt_double),
    .overflow(overflow)
  );

  ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .data_in(data_in),
    .op_done(op_done), .err_in(err_in), .res_if(rif_s),
    .cnt_total(s_total), .cnt_single(s_single), .cnt_double(s_double),
    .overflow(s_ovf)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic logic [DW+2:0] exp_head();
    if (mq.size() == 0) return '0;
    return {1'b1, mq[0][1:0], mq[0][DW+1:2]};
  endfunction

  function automatic logic [48:0] exp_stats16();
    logic [15:0] t, s, d;
    t = 16'(sat(m_total, 65535));
    s = 16'(sat(m_single, 65535));
    d = 16'(sat(m_double, 65535));
    return {t, s, d, m_ovf};
  endfunction

  function automatic logic [12:0] exp_stats4();
    logic [3:0] t, s, d;
    t = 4'(sat(m_total, 15));
    s = 4'(sat(m_single, 15));
    d = 4'(sat(m_double, 15));
    return {t, s, d, m_ovf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_total = 0; m_single = 0; m_double = 0; m_ovf = 0;
  endtask

  // Advance one clock edge, applying the behavioural rules to the model.
  task automatic step();
    logic [1:0] e;
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (ready && mq.size() != 0) void'(mq.pop_front());
      e = (mode == 2'b01 || mode == 2'b10) ? err_in : 2'b00;
      if (op_done) begin
        m_total++;
        if (e == 2'b01) m_single++;
        if (e[1]) m_double++;
        if (mq.size() < DEPTH) mq.push_back({data_in, e});
        else m_ovf = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1; op_done = 0;
    step();
    clear = 0;
  endtask

  task automatic test_reset();
    rst = 0; clear = 0; op_done = 0; ready = 0; mode = 2'b00; err_in = 2'b00; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rif.res_valid, rif.res_err, rif.res_data} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_head: got %h expected 0", {rif.res_valid, rif.res_err, rif.res_data});
    end
    n_checks++;
    if ({cnt_total, cnt_single, cnt_double, overflow} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h expected 0", {cnt_total, cnt_single, cnt_double, overflow});
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_fc_single();
    mode = 2'b10; data_in = 32'hA5A5A5A5; err_in = 2'b01; op_done = 1; ready = 1;
    step();
    op_done = 0;
    n_checks++;
    if ({rif.res_valid, rif.res_err, rif.res_data} !== {1'b1, 2'b01, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL fc_head: got %h expected %h", {rif.res_valid, rif.res_err, rif.res_data},
               {1'b1, 2'b01, 32'hA5A5A5A5});
    end
    n_checks++;
    if ({cnt_total, cnt_single, cnt_double} !== {16'd1, 16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL fc_counts: got %h expected %h", {cnt_total, cnt_single, cnt_double},
               {16'd1, 16'd1, 16'd0});
    end
    step();
    n_checks++;
    if (rif.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fc_popped: got valid=%b expected 0", rif.res_valid);
    end
  endtask

  task automatic test_eo_mode();
    do_clear();
    mode = 2'b00; err_in = 2'b10; data_in = $urandom; op_done = 1; ready = 0;
    step();
    op_done = 0;
    n_checks++;
    if ({rif.res_valid, rif.res_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL eo_err: got valid/err %b expected 100", {rif.res_valid, rif.res_err});
    end
    n_checks++;
    if ({cnt_total, cnt_double} !== {16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL eo_counts: got %h expected %h", {cnt_total, cnt_double}, {16'd1, 16'd0});
    end
    ready = 1;
    step();
    ready = 0;
  endtask

  task automatic test_overflow();
    logic [DW+1:0] sent [5];
    do_clear();
    mode = 2'b10; ready = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = $urandom; err_in = 2'($urandom_range(0, 3)); op_done = 1;
      sent[i] = {data_in, err_in};
      step();
    end
    op_done = 0;
    n_checks++;
    if ({overflow, cnt_total} !== {1'b1, 16'd5}) begin
      n_fail++;
      $display("FAIL ovf_flag: got ovf/total %h expected %h", {overflow, cnt_total}, {1'b1, 16'd5});
    end
    n_checks++;
    if ({cnt_total, cnt_single, cnt_double, overflow} !== exp_stats16()) begin
      n_fail++;
      $display("FAIL ovf_stats: got %h expected %h", {cnt_total, cnt_single, cnt_double, overflow}, exp_stats16());
    end
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rif.res_valid, rif.res_err, rif.res_data} !== {1'b1, sent[i][1:0], sent[i][DW+1:2]}) begin
        n_fail++;
        $display("FAIL ovf_order[%0d]: got %h expected %h", i, {rif.res_valid, rif.res_err, rif.res_data},
                 {1'b1, sent[i][1:0], sent[i][DW+1:2]});
      end
      step();
    end
    n_checks++;
    if (rif.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got valid=%b expected 0", rif.res_valid);
    end
    ready = 0;
  endtask

  task automatic test_full_push_pop();
    logic [DW+1:0] sent [5];
    do_clear();
    mode = 2'b01; ready = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = $urandom; err_in = 2'($urandom_range(0, 3));
      sent[i] = {data_in, err_in};
      op_done = 1;
      if (i == 4) ready = 1;
      step();
    end
    op_done = 0; ready = 0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_ovf: got %b expected 0", overflow);
    end
    ready = 1;
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if ({rif.res_valid, rif.res_err, rif.res_data} !== {1'b1, sent[i][1:0], sent[i][DW+1:2]}) begin
        n_fail++;
        $display("FAIL fpp_order[%0d]: got %h expected %h", i, {rif.res_valid, rif.res_err, rif.res_data},
                 {1'b1, sent[i][1:0], sent[i][DW+1:2]});
      end
      step();
    end
    ready = 0;
  endtask

  task automatic test_saturation();
    do_clear();
    mode = 2'b10; err_in = 2'b01; ready = 1; op_done = 1;
    for (int i = 0; i < 21; i++) begin
      data_in = $urandom;
      step();
    end
    op_done = 0;
    n_checks++;
    if ({s_total, s_single, s_double} !== {4'hF, 4'hF, 4'h0}) begin
      n_fail++;
      $display("FAIL sat_small: got %h expected %h", {s_total, s_single, s_double}, {4'hF, 4'hF, 4'h0});
    end
    n_checks++;
    if ({cnt_total, cnt_single} !== {16'd21, 16'd21}) begin
      n_fail++;
      $display("FAIL sat_wide: got %h expected %h", {cnt_total, cnt_single}, {16'd21, 16'd21});
    end
    clear = 1; op_done = 1; data_in = $urandom;
    step();
    clear = 0; op_done = 0;
    n_checks++;
    if ({rif.res_valid, cnt_total, cnt_single, cnt_double, overflow} !== 50'd0) begin
      n_fail++;
      $display("FAIL clear_push: got %h expected 0", {rif.res_valid, cnt_total, cnt_single, cnt_double, overflow});
    end
    n_checks++;
    if ({s_total, s_single, s_double, s_ovf} !== 13'd0) begin
      n_fail++;
      $display("FAIL clear_small: got %h expected 0", {s_total, s_single, s_double, s_ovf});
    end
    ready = 0;
  endtask

  task automatic test_reset_midstream();
    do_clear();
    mode = 2'b01; ready = 0; op_done = 1;
    for (int i = 0; i < 2; i++) begin
      data_in = $urandom; err_in = 2'($urandom_range(0, 3));
      step();
    end
    op_done = 0;
    n_checks++;
    if ({rif.res_valid, rif.res_err, rif.res_data} !== exp_head()) begin
      n_fail++;
      $display("FAIL mid_before: got %h expected %h", {rif.res_valid, rif.res_err, rif.res_data}, exp_head());
    end
    #2 rst = 0;
    #1;
    model_reset();
    n_checks++;
    if ({rif.res_valid, cnt_total} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_async: got %h expected 0", {rif.res_valid, cnt_total});
    end
    @(negedge clk);
    rst = 1; ready = 1;
    step();
    n_checks++;
    if ({rif.res_valid, cnt_total, cnt_single, cnt_double, overflow} !== 50'd0) begin
      n_fail++;
      $display("FAIL mid_after: got %h expected 0", {rif.res_valid, cnt_total, cnt_single, cnt_double, overflow});
    end
    ready = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear   = ($urandom_range(0, 31) == 0);
      op_done = $urandom_range(0, 1);
      ready   = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mode    = 2'($urandom_range(0, 3));
      err_in  = 2'($urandom_range(0, 3));
      data_in = $urandom;
      step();
      n_checks++;
      if ({rif.res_valid, rif.res_err, rif.res_data} !== exp_head()) begin
        n_fail++;
        $display("FAIL rnd_head[%0d]: got %h expected %h", i, {rif.res_valid, rif.res_err, rif.res_data}, exp_head());
      end
      n_checks++;
      if ({cnt_total, cnt_single, cnt_double, overflow} !== exp_stats16()) begin
        n_fail++;
        $display("FAIL rnd_stats[%0d]: got %h expected %h", i, {cnt_total, cnt_single, cnt_double, overflow}, exp_stats16());
      end
      n_checks++;
      if ({s_total, s_single, s_double, s_ovf} !== exp_stats4()) begin
        n_fail++;
        $display("FAIL rnd_stats4[%0d]: got %h expected %h", i, {s_total, s_single, s_double, s_ovf}, exp_stats4());
      end
      n_checks++;
      if ({rif_s.res_valid, rif_s.res_err, rif_s.res_data} !== exp_head()) begin
        n_fail++;
        $display("FAIL rnd_head4[%0d]: got %h expected %h", i, {rif_s.res_valid, rif_s.res_err, rif_s.res_data}, exp_head());
      end
    end
    clear = 0; op_done = 0; ready = 0;
  endtask

  initial begin
    test_reset();
    test_fc_single();
    test_eo_mode();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
